rv32i_mem_pipe: RTL and testbench
=================================

RV32I_MEM_PIPE -- requirements
Module: rv32i_mem_pipe

Interface
REQ-001 SHALL have parameter XLEN, default 32, data/address width.
REQ-002 SHALL have parameter BUS_AW, default 30, word-address width (XLEN-2).
REQ-003 SHALL use one clock and a synchronous, active-high reset.
REQ-004 clk_i  in  1  sole clock, all state on rising edge.
REQ-005 reset_i  in  1  synchronous active-high reset.
REQ-006 clear_i  in  1  pipeline flush from the branch logic.
REQ-007 data_ready_i  in  1  upstream (ALU) result valid this cycle.
REQ-008 mem_read_i, mem_write_i  in  1 each  load/store op; never both high.
REQ-009 funct3_i  in  3  RV32I width code (LB/LH/LW/LBU/LHU/SB/SH/SW).
REQ-010 address_i  in  XLEN  ALU result: effective address or pass-through value.
REQ-011 store_data_i  in  XLEN  rs2 value for stores.
REQ-012 rd_i / rd_o  in / out  5  destination register, carried alongside data.
REQ-013 stall_o  out  1  upstream must hold and not present new data.
REQ-014 data_ready_o  out  1  one-cycle pulse, result_o/rd_o valid.
REQ-015 result_o  out  XLEN  writeback value.
REQ-016 misalign_o  out  1  misaligned-access flag, qualified by data_ready_o.
REQ-017 bus_stb_o, bus_we_o  out  1 each  bus request, write enable.
REQ-018 bus_addr_o  out  BUS_AW  word address (address_i[XLEN-1:2]).
REQ-019 bus_sel_o  out  4  byte-lane enables; bus_data_o  out  XLEN  write data.
REQ-020 bus_data_i  in  XLEN  read data; bus_ack_i  in  1  transfer complete.

Function
REQ-021 States SHALL be IDLE, BUS, DRAIN.
REQ-022 IDLE, data_ready_i, no mem op: next cycle result_o=address_i, rd_o=rd_i, data_ready_o=1 (latency 1).
REQ-023 IDLE, data_ready_i with mem op: latch address, lanes, data, direction; go to BUS; bus_stb_o=1 from next cycle.
REQ-024 stall_o SHALL equal (state != IDLE); upstream holds data_ready_i low while stall_o=1.
REQ-025 BUS: bus_stb_o and all bus outputs held stable until bus_ack_i sampled high.
REQ-026 BUS and bus_ack_i: next cycle bus_stb_o=0, data_ready_o=1, state IDLE; load result_o = aligned bus_data_i, store result_o=0.
REQ-027 Lanes: byte sel=1<<addr[1:0]; half sel=0011 (addr[1]=0) or 1100; word sel=1111.
REQ-028 Stores replicate: byte into all four lanes, half into both halves.
REQ-029 LB/LH sign-extend; LBU/LHU zero-extend; selected lane from latched addr.
REQ-030 clear_i in IDLE: data_ready_o=0 next cycle, input ignored.
REQ-031 clear_i in BUS without ack: go to DRAIN; bus cycle not aborted.
REQ-032 DRAIN: keep bus_stb_o until bus_ack_i, then IDLE; no data_ready_o.
REQ-033 clear_i and bus_ack_i same cycle in BUS: transfer completes, result discarded, IDLE.
REQ-034 data_ready_o SHALL be 0 in any cycle not named in REQ-022/026/039.

Reset
REQ-035 reset_i SHALL override clear_i and all inputs, also mid-bus-cycle.
REQ-036 Reset values: state IDLE, stall_o, data_ready_o, misalign_o, bus_stb_o, bus_we_o = 0; result_o, rd_o, bus_addr_o, bus_sel_o, bus_data_o = 0.

Configuration
REQ-037 Macro RV32I_MEM_MISALIGN_EN SHALL select misalignment handling.
REQ-038 Defined: misaligned = half with addr[0]=1, or word with addr[1:0]!=0.
REQ-039 Defined, misaligned: no bus cycle; next cycle data_ready_o=1, misalign_o=1, result_o=address_i.
REQ-040 Undefined: misalign_o tied 0; halfword ignores addr[0], word ignores addr[1:0].

Structure
REQ-041 Package rv32i_pkg SHALL hold funct3 width codes, state encoding, and XLEN default.
REQ-042 Sub-module rv32i_load_align SHALL hold combinational lane extract and sign/zero extend.

Verification
REQ-043 ADD pass-through: address_i=0x1234, rd_i=5 -> next cycle data_ready_o=1, result_o=0x1234, rd_o=5, no bus_stb_o.
REQ-044 LB addr 0x103, bus_data_i=0x80AABBCC, ack after 3 cycles -> sel 1000, stall_o 3 cycles, result_o=0xFFFFFF80.
REQ-045 SH addr 0x202, store 0x0000BEEF -> bus_addr_o=0x80, sel 1100, bus_data_o=0xBEEFBEEF, we=1, result_o=0.
REQ-046 LW in BUS, clear_i pulsed, ack 2 cycles later -> stb held to ack, DRAIN, no data_ready_o, IDLE.
REQ-047 RV32I_MEM_MISALIGN_EN, LW addr 0x101 -> no bus_stb_o, next cycle misalign_o=1, result_o=0x101.
REQ-048 reset_i during BUS -> next cycle all outputs 0, IDLE; later ack ignored.

Source files
------------

// File: rtl/rv32i_pkg.sv
// rv32i_pkg: shared width codes, stage states and lane-select helper for the RV32I memory stage
package rv32i_pkg;
  localparam int XLEN_DEF = 32;
  localparam logic [1:0] SZ_B = 2'b00;
  localparam logic [1:0] SZ_H = 2'b01;
  localparam logic [1:0] SZ_W = 2'b10;
  typedef enum logic [1:0] {IDLE, BUS, DRAIN} state_e;
  function automatic logic [3:0] lane_sel(input logic [1:0] size, input logic [1:0] off);
    return size == SZ_B ? 4'b0001 << off : size == SZ_H ? (off[1] ? 4'b1100 : 4'b0011) : 4'b1111;
  endfunction
endpackage

// File: rtl/rv32i_load_align.sv
// rv32i_load_align: extracts the addressed byte/half from a bus word and sign- or zero-extends it
module rv32i_load_align import rv32i_pkg::*; #(
  parameter int XLEN = XLEN_DEF
) (
  input  logic [2:0]      funct3_i,
  input  logic [1:0]      off_i,
  input  logic [XLEN-1:0] data_i,
  output logic [XLEN-1:0] data_o
);
  logic [7:0] b;
  logic [15:0] h;
  always_comb begin
    b = data_i[8*off_i +: 8];
    h = off_i[1] ? data_i[31:16] : data_i[15:0];
    data_o = funct3_i[1:0] == SZ_W ? data_i
           : funct3_i[1:0] == SZ_H ? {{(XLEN-16){~funct3_i[2] & h[15]}}, h}
           : {{(XLEN-8){~funct3_i[2] & b[7]}}, b};
  end
endmodule

// File: rtl/rv32i_mem_pipe.sv
// rv32i_mem_pipe: RV32I memory stage, one outstanding bus cycle with flush/drain handling.
// Define RV32I_MEM_MISALIGN_EN to flag misaligned half/word accesses instead of issuing them.
module rv32i_mem_pipe import rv32i_pkg::*; #(
  parameter int XLEN   = XLEN_DEF,
  parameter int BUS_AW = XLEN - 2
) (
  input  logic              clk_i,
  input  logic              reset_i,
  input  logic              clear_i,
  input  logic              data_ready_i,
  input  logic              mem_read_i,
  input  logic              mem_write_i,
  input  logic [2:0]        funct3_i,
  input  logic [XLEN-1:0]   address_i,
  input  logic [XLEN-1:0]   store_data_i,
  input  logic [4:0]        rd_i,
  output logic [4:0]        rd_o,
  output logic              stall_o,
  output logic              data_ready_o,
  output logic [XLEN-1:0]   result_o,
  output logic              misalign_o,
  output logic              bus_stb_o,
  output logic              bus_we_o,
  output logic [BUS_AW-1:0] bus_addr_o,
  output logic [3:0]        bus_sel_o,
  output logic [XLEN-1:0]   bus_data_o,
  input  logic [XLEN-1:0]   bus_data_i,
  input  logic              bus_ack_i
);
  state_e state_q, state_d;
  logic [XLEN-1:0] result_q, result_d, data_q, data_d, load_data;
  logic [BUS_AW-1:0] addr_q, addr_d;
  logic [4:0] rd_q, rd_d;
  logic [3:0] sel_q, sel_d;
  logic [2:0] f3_q, f3_d;
  logic [1:0] off_q, off_d;
  logic dr_q, dr_d, mis_q, mis_d, we_q, we_d, mis, mem_op;
`ifdef RV32I_MEM_MISALIGN_EN
  assign mis = (funct3_i[1:0] == SZ_H && address_i[0]) || (funct3_i[1:0] == SZ_W && address_i[1:0] != 2'b00);
`else
  assign mis = 1'b0;
`endif
  assign mem_op = mem_read_i | mem_write_i;
  rv32i_load_align #(.XLEN(XLEN)) u_align (
    .funct3_i(f3_q),
    .off_i(off_q),
    .data_i(bus_data_i),
    .data_o(load_data)
  );
  always_comb begin
    state_d = state_q;
    result_d = result_q;
    rd_d = rd_q;
    dr_d = 1'b0;
    mis_d = 1'b0;
    we_d = we_q;
    addr_d = addr_q;
    sel_d = sel_q;
    data_d = data_q;
    f3_d = f3_q;
    off_d = off_q;
    if (state_q == IDLE) begin
      if (data_ready_i && !clear_i) begin
        rd_d = rd_i;
        if (mem_op && !mis) begin
          state_d = BUS;
          we_d = mem_write_i;
          addr_d = address_i[XLEN-1:2];
          sel_d = lane_sel(funct3_i[1:0], address_i[1:0]);
          data_d = funct3_i[1:0] == SZ_B ? {(XLEN/8){store_data_i[7:0]}}
                 : funct3_i[1:0] == SZ_H ? {(XLEN/16){store_data_i[15:0]}} : store_data_i;
          f3_d = funct3_i;
          off_d = address_i[1:0];
        end else begin
          dr_d = 1'b1;
          result_d = address_i;
          mis_d = mis & mem_op;
        end
      end
    end else if (bus_ack_i) begin
      state_d = IDLE;
      dr_d = state_q == BUS && !clear_i;
      result_d = dr_d ? (we_q ? '0 : load_data) : result_q;
    end else if (clear_i) begin
      state_d = DRAIN;
    end
  end
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q <= IDLE;
      result_q <= '0;
      rd_q <= '0;
      dr_q <= 1'b0;
      mis_q <= 1'b0;
      we_q <= 1'b0;
      addr_q <= '0;
      sel_q <= '0;
      data_q <= '0;
      f3_q <= '0;
      off_q <= '0;
    end else begin
      state_q <= state_d;
      result_q <= result_d;
      rd_q <= rd_d;
      dr_q <= dr_d;
      mis_q <= mis_d;
      we_q <= we_d;
      addr_q <= addr_d;
      sel_q <= sel_d;
      data_q <= data_d;
      f3_q <= f3_d;
      off_q <= off_d;
    end
  end
  assign stall_o = state_q != IDLE;
  assign bus_stb_o = stall_o;
  assign bus_we_o = we_q;
  assign bus_addr_o = addr_q;
  assign bus_sel_o = sel_q;
  assign bus_data_o = data_q;
  assign data_ready_o = dr_q;
  assign result_o = result_q;
  assign rd_o = rd_q;
  assign misalign_o = mis_q;
endmodule

// File: tb/tb_rv32i_mem_pipe.sv
// tb_rv32i_mem_pipe: vector table plus scoreboard for rv32i_mem_pipe, with flush/drain/reset sequences
module tb_rv32i_mem_pipe;
  logic clk = 0, reset_i = 1, clear_i = 0, data_ready_i = 0, mem_read_i = 0, mem_write_i = 0;
  logic [2:0] funct3_i = 0;
  logic [31:0] address_i = 0, store_data_i = 0, bus_data_i = 32'h5A5A5A5A;
  logic [4:0] rd_i = 0, rd_o;
  logic bus_ack_i = 0, stall_o, data_ready_o, misalign_o, bus_stb_o, bus_we_o;
  logic [31:0] result_o, bus_data_o;
  logic [29:0] bus_addr_o;
  logic [3:0] bus_sel_o;
  int n_chk = 0, n_fail = 0;

  rv32i_mem_pipe dut (
    .clk_i(clk), .reset_i(reset_i), .clear_i(clear_i), .data_ready_i(data_ready_i),
    .mem_read_i(mem_read_i), .mem_write_i(mem_write_i), .funct3_i(funct3_i),
    .address_i(address_i), .store_data_i(store_data_i), .rd_i(rd_i), .rd_o(rd_o),
    .stall_o(stall_o), .data_ready_o(data_ready_o), .result_o(result_o),
    .misalign_o(misalign_o), .bus_stb_o(bus_stb_o), .bus_we_o(bus_we_o),
    .bus_addr_o(bus_addr_o), .bus_sel_o(bus_sel_o), .bus_data_o(bus_data_o),
    .bus_data_i(bus_data_i), .bus_ack_i(bus_ack_i)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [4:0] rd; logic rd_en, wr_en; logic [2:0] f3;
    logic [31:0] addr, wdata, rdata; int dly;
    logic bus; logic [3:0] sel; logic [31:0] bdata, res; logic mis;
  } vec_t;
  typedef struct { logic [31:0] res; logic [4:0] rd; logic mis; } exp_t;
  exp_t sb[$];
  vec_t v[11];

  function automatic void chk(string n, logic [31:0] act, logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", n, act, exp, $time);
    end
  endfunction

  function automatic vec_t mk(logic [4:0] rd, logic r, logic w, logic [2:0] f3, logic [31:0] a,
                              logic [31:0] wd, logic [31:0] rdat, int d, logic b, logic [3:0] s,
                              logic [31:0] bd, logic [31:0] res, logic m);
    vec_t t;
    t.rd = rd; t.rd_en = r; t.wr_en = w; t.f3 = f3; t.addr = a; t.wdata = wd; t.rdata = rdat;
    t.dly = d; t.bus = b; t.sel = s; t.bdata = bd; t.res = res; t.mis = m;
    return t;
  endfunction

  always @(negedge clk) begin
    if (!reset_i && data_ready_o) begin
      if (sb.size() == 0) chk("unexpected_data_ready", 1, 0);
      else begin
        exp_t e;
        e = sb.pop_front();
        chk("result", result_o, e.res);
        chk("rd", {27'd0, rd_o}, {27'd0, e.rd});
        chk("misalign", {31'd0, misalign_o}, {31'd0, e.mis});
      end
    end
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic run(vec_t t);
    exp_t e;
    data_ready_i = 1; mem_read_i = t.rd_en; mem_write_i = t.wr_en; funct3_i = t.f3;
    address_i = t.addr; store_data_i = t.wdata; rd_i = t.rd;
    e.res = t.res; e.rd = t.rd; e.mis = t.mis;
    sb.push_back(e);
    tick();
    data_ready_i = 0; mem_read_i = 0; mem_write_i = 0; address_i = 32'hFFFF_FFFF; rd_i = 0;
    if (t.bus) begin
      for (int k = 1; k <= t.dly; k++) begin
        chk("stb_held", {31'd0, bus_stb_o}, 1);
        chk("stall_held", {31'd0, stall_o}, 1);
        chk("bus_addr", {2'd0, bus_addr_o}, {2'd0, t.addr[31:2]});
        chk("bus_sel", {28'd0, bus_sel_o}, {28'd0, t.sel});
        chk("bus_we", {31'd0, bus_we_o}, {31'd0, t.wr_en});
        if (t.wr_en) chk("bus_wdata", bus_data_o, t.bdata);
        if (k == t.dly) begin bus_ack_i = 1; bus_data_i = t.rdata; end
        tick();
      end
      bus_ack_i = 0; bus_data_i = 32'h5A5A5A5A;
    end else chk("no_stb", {31'd0, bus_stb_o}, 0);
    chk("stb_released", {31'd0, bus_stb_o}, 0);
    chk("stall_released", {31'd0, stall_o}, 0);
    chk("dr_pulse", {31'd0, data_ready_o}, 1);
    tick();
    chk("dr_one_cycle", {31'd0, data_ready_o}, 0);
  endtask

  task automatic start_lw(logic [31:0] a);
    data_ready_i = 1; mem_read_i = 1; funct3_i = 3'b010; address_i = a; rd_i = 5'd9;
    tick();
    data_ready_i = 0; mem_read_i = 0;
  endtask

  initial begin
    v[0]  = mk(5,  0, 0, 3'b000, 32'h1234,     0,            0,            0, 0, 4'b0000, 0,            32'h1234,     0);
    v[1]  = mk(7,  1, 0, 3'b000, 32'h103,      0,            32'h80AABBCC, 3, 1, 4'b1000, 0,            32'hFFFFFF80, 0);
    v[2]  = mk(3,  0, 1, 3'b001, 32'h202,      32'h0000BEEF, 0,            2, 1, 4'b1100, 32'hBEEFBEEF, 0,            0);
    v[3]  = mk(1,  1, 0, 3'b010, 32'h400,      0,            32'hDEADBEEF, 1, 1, 4'b1111, 0,            32'hDEADBEEF, 0);
    v[4]  = mk(2,  1, 0, 3'b100, 32'h101,      0,            32'h80AABBCC, 2, 1, 4'b0010, 0,            32'h000000BB, 0);
    v[5]  = mk(4,  1, 0, 3'b101, 32'h002,      0,            32'h80AABBCC, 1, 1, 4'b1100, 0,            32'h000080AA, 0);
    v[6]  = mk(6,  1, 0, 3'b001, 32'h000,      0,            32'h1234F00D, 4, 1, 4'b0011, 0,            32'hFFFFF00D, 0);
    v[7]  = mk(8,  0, 1, 3'b000, 32'h011,      32'h123456A5, 0,            1, 1, 4'b0010, 32'hA5A5A5A5, 0,            0);
    v[8]  = mk(31, 0, 1, 3'b010, 32'h20,       32'hCAFEF00D, 0,            2, 1, 4'b1111, 32'hCAFEF00D, 0,            0);
`ifdef RV32I_MEM_MISALIGN_EN
    v[9]  = mk(10, 1, 0, 3'b010, 32'h101,      0,            32'h11223344, 1, 0, 4'b0000, 0,            32'h101,      1);
    v[10] = mk(11, 0, 1, 3'b001, 32'h203,      32'h0000BEEF, 0,            1, 0, 4'b0000, 0,            32'h203,      1);
`else
    v[9]  = mk(10, 1, 0, 3'b010, 32'h101,      0,            32'h11223344, 1, 1, 4'b1111, 0,            32'h11223344, 0);
    v[10] = mk(11, 0, 1, 3'b001, 32'h203,      32'h0000BEEF, 0,            1, 1, 4'b1100, 32'hBEEFBEEF, 0,            0);
`endif
    tick(); tick();
    chk("rst_stall", {31'd0, stall_o}, 0);
    chk("rst_stb", {31'd0, bus_stb_o}, 0);
    chk("rst_dr", {31'd0, data_ready_o}, 0);
    chk("rst_result", result_o, 0);
    chk("rst_outs", {bus_addr_o, bus_sel_o, bus_we_o, misalign_o, rd_o}, 0);
    reset_i = 0;
    tick();
    for (int i = 0; i < 11; i++) run(v[i]);

    // flush in IDLE: input dropped
    data_ready_i = 1; clear_i = 1; address_i = 32'h55; rd_i = 5'd3;
    tick();
    data_ready_i = 0; clear_i = 0;
    chk("clr_idle_dr", {31'd0, data_ready_o}, 0);
    chk("clr_idle_stall", {31'd0, stall_o}, 0);

    // flush mid-bus: drain until ack, no result
    start_lw(32'h300);
    chk("drain_stb0", {31'd0, bus_stb_o}, 1);
    clear_i = 1;
    tick();
    clear_i = 0;
    chk("drain_stb1", {31'd0, bus_stb_o}, 1);
    chk("drain_stall1", {31'd0, stall_o}, 1);
    chk("drain_addr", {2'd0, bus_addr_o}, 32'hC0);
    tick();
    chk("drain_stb2", {31'd0, bus_stb_o}, 1);
    chk("drain_dr", {31'd0, data_ready_o}, 0);
    bus_ack_i = 1; bus_data_i = 32'h77777777;
    tick();
    bus_ack_i = 0; bus_data_i = 32'h5A5A5A5A;
    chk("drain_done_stb", {31'd0, bus_stb_o}, 0);
    chk("drain_done_dr", {31'd0, data_ready_o}, 0);
    chk("drain_done_stall", {31'd0, stall_o}, 0);

    // flush and ack together: transfer completes, result discarded
    start_lw(32'h304);
    clear_i = 1; bus_ack_i = 1; bus_data_i = 32'h66666666;
    tick();
    clear_i = 0; bus_ack_i = 0; bus_data_i = 32'h5A5A5A5A;
    chk("clr_ack_dr", {31'd0, data_ready_o}, 0);
    chk("clr_ack_stb", {31'd0, bus_stb_o}, 0);
    tick();
    chk("clr_ack_idle", {31'd0, stall_o}, 0);

    // reset mid-bus overrides everything; late ack ignored
    start_lw(32'h308);
    chk("rstbus_stb_pre", {31'd0, bus_stb_o}, 1);
    reset_i = 1; clear_i = 1;
    tick();
    reset_i = 0; clear_i = 0;
    chk("rstbus_stb", {31'd0, bus_stb_o}, 0);
    chk("rstbus_stall", {31'd0, stall_o}, 0);
    chk("rstbus_outs", {bus_addr_o, bus_sel_o, bus_we_o, misalign_o, data_ready_o}, 0);
    chk("rstbus_result", result_o, 0);
    bus_ack_i = 1; bus_data_i = 32'h12345678;
    tick();
    bus_ack_i = 0;
    chk("late_ack_dr", {31'd0, data_ready_o}, 0);
    chk("late_ack_stb", {31'd0, bus_stb_o}, 0);

    run(v[0]);
    tick();
    chk("scoreboard_empty", sb.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
